// File: rtl/cmp_serial_verdict.sv
// Bit-serial magnitude comparator consumer: folds MSB-first per-bit flag triples
// into a word verdict presented on a valid/ready result port.
module cmp_serial_verdict #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          gt,
    input  logic          ls,
    input  logic          eq,
    input  logic          res_ready,
    output logic          busy,
    output logic          res_valid,
    output logic          a_gt_b,
    output logic          a_lt_b,
    output logic          a_eq_b,
    output logic          err,
    output logic [CW-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic decided;
    logic dec_gt;
    logic dec_lt;
    logic accept;
    logic onehot;
    logic start_word;
    logic last_bit;

    assign accept   = (state == ACCUM) && bit_valid;
    assign onehot   = (gt & ~ls & ~eq) | (~gt & ls & ~eq) | (~gt & ~ls & eq);
    assign last_bit = accept && (bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt  = state;
        start_word = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = ACCUM;
                    start_word = 1'b1;
                end
            end
            ACCUM: begin
                if (last_bit)
                    state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    if (start) begin
                        state_nxt  = ACCUM;
                        start_word = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Only the first legal gt/ls bit fixes the verdict; illegal triples count as eq.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            dec_lt  <= 1'b0;
            err     <= 1'b0;
        end else if (start_word) begin
            bit_cnt <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            dec_lt  <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + CW'(1);
            if (!onehot)
                err <= 1'b1;
            else if (!decided && (gt || ls)) begin
                decided <= 1'b1;
                dec_gt  <= gt;
                dec_lt  <= ls;
            end
        end
    end

    assign busy      = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign a_gt_b    = (state == DONE) && dec_gt;
    assign a_lt_b    = (state == DONE) && dec_lt;
    assign a_eq_b    = (state == DONE) && !decided;

endmodule

// File: tb/tb_cmp_serial_verdict.sv
// Directed bench for cmp_serial_verdict: stimulus pushes hand-computed verdicts,
// a monitor pops and compares them on every result handshake.
module tb_cmp_serial_verdict;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          bit_valid = 1'b0;
    logic          gt = 1'b0;
    logic          ls = 1'b0;
    logic          eq = 1'b0;
    logic          res_ready = 1'b1;
    logic          busy;
    logic          res_valid;
    logic          a_gt_b;
    logic          a_lt_b;
    logic          a_eq_b;
    logic          err;
    logic [CW-1:0] bit_cnt;

    typedef struct packed {
        logic          vgt;
        logic          vlt;
        logic          veq;
        logic          verr;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    cmp_serial_verdict #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .gt(gt), .ls(ls), .eq(eq), .res_ready(res_ready),
        .busy(busy), .res_valid(res_valid), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
        .a_eq_b(a_eq_b), .err(err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one pop per result handshake.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("verdict_gt", 32'(a_gt_b), 32'(e.vgt));
                chk("verdict_lt", 32'(a_lt_b), 32'(e.vlt));
                chk("verdict_eq", 32'(a_eq_b), 32'(e.veq));
                chk("verdict_err", 32'(err), 32'(e.verr));
                chk("verdict_cnt", 32'(bit_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cnt_after_start", 32'(bit_cnt), 32'd0);
    endtask

    task automatic send_triple(input logic g, input logic l, input logic e, input int gap);
        bit_valid = 1'b0;
        repeat (gap) step();
        gt = g; ls = l; eq = e;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        gt = 1'b0; ls = 1'b0; eq = 1'b0;
    endtask

    // Drives the top nbits of a/b as per-bit triples, MSB first.
    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int gap, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            send_triple(a[i] & ~b[i], ~a[i] & b[i], a[i] == b[i], gap);
            if (i == 1)
                chk("no_early_valid", 32'(res_valid), 32'd0);
        end
        if (nbits == WIDTH) begin
            chk("valid_after_last", 32'(res_valid), 32'd1);
            chk("busy_after_last", 32'(busy), 32'd0);
        end
    endtask

    task automatic push(input logic g, input logic l, input logic e, input logic er);
        exp_t x;
        x.vgt = g; x.vlt = l; x.veq = e; x.verr = er; x.cnt = CW'(WIDTH);
        exp_q.push_back(x);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_verdict", 32'({a_gt_b, a_lt_b, a_eq_b, err}), 32'd0);
        chk("rst_cnt", 32'(bit_cnt), 32'd0);
        step();
        rst = 1'b1;
        send_triple(1'b1, 1'b0, 1'b0, 0);
        send_triple(1'b0, 1'b1, 1'b0, 1);
        send_triple(1'b1, 1'b1, 1'b1, 0);
        chk("idle_cnt", 32'(bit_cnt), 32'd0);
        chk("idle_outs", 32'({busy, res_valid, a_gt_b, a_lt_b, a_eq_b, err}), 32'd0);

        // Greater: 0xA5 vs 0x95
        push(1'b1, 1'b0, 1'b0, 1'b0);
        do_start();
        send_bits(8'hA5, 8'h95, 0, 8);
        step();

        // Equal and less with 3-cycle gaps
        push(1'b0, 1'b0, 1'b1, 1'b0);
        do_start();
        send_bits(8'h3C, 8'h3C, 3, 8);
        step();
        push(1'b0, 1'b1, 1'b0, 1'b0);
        do_start();
        send_bits(8'h01, 8'h80, 3, 8);
        step();

        // Hold with res_ready low, then back-to-back
        push(1'b1, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b0;
        do_start();
        send_bits(8'hF0, 8'h0F, 0, 8);
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            step();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_verdict", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b100);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        push(1'b0, 1'b1, 1'b0, 1'b0);
        res_ready = 1'b1;
        do_start();
        chk("b2b_valid_low", 32'(res_valid), 32'd0);
        send_bits(8'h0F, 8'hF0, 0, 8);
        step();

        // Illegal flag triples: 110 at bit 7, 000 at bit 6, rest eq
        push(1'b0, 1'b0, 1'b1, 1'b1);
        do_start();
        send_triple(1'b1, 1'b1, 1'b0, 0);
        send_triple(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            send_triple(1'b0, 1'b0, 1'b1, 0);
        chk("illegal_valid", 32'(res_valid), 32'd1);
        step();
        push(1'b1, 1'b0, 1'b0, 1'b0);
        do_start();
        chk("err_cleared", 32'(err), 32'd0);
        send_bits(8'h80, 8'h7F, 0, 8);
        step();

        // Reset mid-word
        do_start();
        send_bits(8'h12, 8'h34, 0, 4);
        chk("mid_cnt", 32'(bit_cnt), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_cnt", 32'(bit_cnt), 32'd0);
        chk("async_outs", 32'({res_valid, a_gt_b, a_lt_b, a_eq_b, err}), 32'd0);
        step();
        rst = 1'b1;
        push(1'b0, 1'b1, 1'b0, 1'b0);
        do_start();
        send_bits(8'h10, 8'h20, 0, 8);
        step();
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_serial_verdict.md
# cmp_serial_verdict

Consumer end of the bit-serial comparator interface. Accepts one per-bit flag triple (gt, ls, eq) per cycle from the 1-bit comparator, MSB first. After WIDTH bits it resolves the magnitude relation of the two WIDTH-bit operands. It presents the verdict on a valid/ready result port.

## Interface

- WIDTH, 8: operand width in bits; number of flag triples per word (≥2).
- CW, $clog2(WIDTH+1): width of bit counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a new word; sampled only in IDLE or DONE.
- bit_valid  input  1  flag triple on gt/ls/eq is valid this cycle.
- gt  input  1  current bit a>b.
- ls  input  1  current bit a<b.
- eq  input  1  current bit a==b.
- res_ready  input  1  downstream accepts result.
- busy  output  1  high in ACCUM.
- res_valid  output  1  high in DONE; verdict stable.
- a_gt_b  output  1  word verdict a>b.
- a_lt_b  output  1  word verdict a<b.
- a_eq_b  output  1  word verdict a==b.
- err  output  1  at least one bit of the word had a non-one-hot flag triple.
- bit_cnt  output  CW  bits accepted in the current word.

## Operation

- FSM has three states: IDLE, ACCUM, DONE. It is one-hot or binary at implementer choice and is not visible externally.
- IDLE:
  - start=1 → ACCUM; clear bit_cnt, decided, dec_gt, dec_lt, and err.
  - bit_valid is ignored.
- ACCUM:
  - Each cycle with bit_valid=1 is one accepted bit; increment bit_cnt.
  - Decision rule, MSB first: the first accepted bit with gt=1 or ls=1 (one-hot) fixes the verdict and sets decided. Later bits do not change the verdict but are still counted.
  - A flag triple that is not exactly one-hot (000, 011, 101, 110, 111) sets err, which is sticky for the word. That bit is treated as eq.
  - On acceptance of the WIDTH-th bit → DONE.
  - start is ignored in ACCUM.
- DONE:
  - res_valid=1.
  - a_gt_b = dec_gt, a_lt_b = dec_lt, a_eq_b = !decided. Exactly one verdict bit is high.
  - Outputs hold until a handshake (res_valid & res_ready).
  - Handshake with start=0 → IDLE.
  - Handshake with start=1 → ACCUM directly (back-to-back word), with the same clears as from IDLE.
  - start without res_ready is ignored.
  - bit_valid is ignored.
- Verdict outputs are 0 outside DONE.
- err and bit_cnt remain readable in DONE and are cleared when the next word starts.
- rst low at any time, including mid-word or in DONE, forces IDLE immediately and discards any partial word.

## Timing

- Reset values: busy=0, res_valid=0, a_gt_b=0, a_lt_b=0, a_eq_b=0, err=0, bit_cnt=0; state=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- start sampled at edge k → busy=1 after edge k. The first bit can be accepted at edge k+1.
- WIDTH-th bit accepted at edge m → res_valid=1 and verdict valid after edge m; busy=0 after edge m.
- Minimum word latency from start: WIDTH+1 edges.
- Back-to-back throughput: one word per WIDTH+1 cycles when res_ready is held at 1.
- Gaps in bit_valid stall accumulation with no timeout.
- Handshake at edge n → res_valid=0 after edge n (IDLE), or busy=1 after edge n (back-to-back).

## Test plan

- Reset and idle: rst=0 then release; bit_valid pulses with no start → all outputs stay 0; bit_cnt=0.
- Greater verdict, WIDTH=8: a=0xA5, b=0x95, driven as per-bit triples MSB first.
  - First difference is at bit 5 (gt); bit 4 is ls.
  - Required: a_gt_b=1, a_lt_b=0, a_eq_b=0, err=0, bit_cnt=8.
  - res_valid rises exactly one edge after the 8th bit.
- Equal and less: a=b=0x3C → a_eq_b=1. Then a=0x01, b=0x80 → a_lt_b=1, decided at the MSB.
  - Insert bit_valid gaps of 3 cycles between bits; verdicts are unchanged.
- Hold and back-to-back:
  - res_ready=0 for 5 cycles in DONE → verdict and res_valid stable; start ignored.
  - Then res_ready=1 with start=1 → busy=1 on the next cycle, counter cleared, second word verdict correct.
- Illegal flags: triple 110 at bit 7 and 000 at bit 6, remaining bits eq → err=1, a_eq_b=1. The next word has err=0.
- Reset mid-operation: assert rst after 4 accepted bits → outputs return to reset values asynchronously. A new start then completes a full 8-bit word normally.
